iob_uart_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares one UART core transmit path between N_CH byte-stream requesters. Holds a grant for a whole packet, delimited by req_last_i, and feeds the core's tx data / data-write-enable / tx-ready interface one byte at a time. Sits between on-chip producers (CPU firmware path, debug/trace sources) and uart_core. Provides stall timeout so a dead requester cannot lock the line.

---
 rtl/iob_uart_tx_sched.sv | 189 ++++++++++++++++++
 tb/tb_iob_uart_tx_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_uart_tx_sched.sv
// Round-robin packet scheduler sharing one uart_core transmit path between N_CH requesters.
// Define IOB_UART_TX_SCHED_HDR_EN to prefix every packet with header byte 8'hF0 | channel.
module iob_uart_tx_sched #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              en_i,
  input  logic [N_CH-1:0]   req_valid_i,
  input  logic [8*N_CH-1:0] req_data_i,
  input  logic [N_CH-1:0]   req_last_i,
  output logic [N_CH-1:0]   req_ready_o,
  input  logic              tx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_wr_o,
  output logic [N_CH-1:0]   grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned     IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned     OFF_W   = IDX_W + 3;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

`ifdef IOB_UART_TX_SCHED_HDR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2, HDR = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} state_e;
`endif

  state_e            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic              gap_q, gap_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  cand;
  logic [OFF_W-1:0]  g_off;
  logic [7:0]        g_byte;
  logic              acc_ok;
  logic              accept;
  logic              stall;

  // First valid channel after the pointer, wrapping at N_CH-1
  always_comb begin : arb_search
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % N_CH);
      if (!sel_found && req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin : xfer_ctrl
    g_off  = {gidx_q, 3'b000};
    g_byte = req_data_i[g_off +: 8];
    acc_ok = (state_q == XFER) & tx_ready_i & cke_i;
    accept = acc_ok & req_valid_i[gidx_q];
    stall  = (state_q == XFER) & tx_ready_i & ~req_valid_i[gidx_q];
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    timeout_d = 1'b0;
    last_d    = last_q;
    gap_d     = gap_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (en_i && sel_found) begin
          grant_d  = N_CH'(1) << sel_idx;
          gidx_d   = sel_idx;
          to_cnt_d = '0;
`ifdef IOB_UART_TX_SCHED_HDR_EN
          state_d  = HDR;
`else
          state_d  = XFER;
`endif
        end
      end
      XFER: begin
        if (accept) begin
          tx_data_d = g_byte;
          tx_wr_d   = 1'b1;
          last_d    = req_last_i[gidx_q];
          gap_d     = 1'b0;
          to_cnt_d  = '0;
          state_d   = GAP;
        end else if (TO_EN && stall) begin
          // Stalled owner with the core ready: revoke before it locks the line
          if (to_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            ptr_d     = gidx_q;
            grant_d   = '0;
            state_d   = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q) begin
          gap_d = 1'b0;
          if (last_q) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            to_cnt_d = '0;
            state_d  = XFER;
          end
        end else begin
          gap_d = 1'b1;
        end
      end
`ifdef IOB_UART_TX_SCHED_HDR_EN
      HDR: begin
        if (tx_ready_i) begin
          tx_data_d = {4'hF, 4'(gidx_q)};
          tx_wr_d   = 1'b1;
          last_d    = 1'b0;
          gap_d     = 1'b0;
          state_d   = GAP;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Clock enable low freezes every flop, including a pending write strobe
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= IDX_W'(N_CH - 1);
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      gap_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else if (cke_i) begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign req_ready_o = grant_q & {N_CH{acc_ok}};
  assign tx_data_o   = tx_data_q;
  assign tx_wr_o     = tx_wr_q & cke_i;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_iob_uart_tx_sched.sv
// Scoreboard bench for iob_uart_tx_sched with four channels and a short stall timeout.
module tb_iob_uart_tx_sched;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TO_W    = 16;
  localparam int unsigned DEPTH   = 16;
`ifdef IOB_UART_TX_SCHED_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              cke = 1'b1;
  logic              en = 1'b1;
  logic              tx_ready = 1'b1;
  logic [N_CH-1:0]   req_valid = '0;
  logic [8*N_CH-1:0] req_data = '0;
  logic [N_CH-1:0]   req_last = '0;
  logic [N_CH-1:0]   req_ready_o;
  logic [7:0]        tx_data_o;
  logic              tx_wr_o;
  logic [N_CH-1:0]   grant_o;
  logic              busy_o;
  logic              timeout_o;

  logic [8:0]        mem [N_CH][DEPTH];
  int unsigned       rd [N_CH];
  int unsigned       wr [N_CH];
  logic [11:0]       exp_q [$];
  int                n_chk = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                n_strobe = 0;
  int                last_strobe = 0;

  always #5 clk = ~clk;

  iob_uart_tx_sched #(.N_CH(N_CH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .cke_i       (cke),
    .en_i        (en),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready_o),
    .tx_ready_i  (tx_ready),
    .tx_data_o   (tx_data_o),
    .tx_wr_o     (tx_wr_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d, input logic l);
    mem[ch][4'(wr[ch])] = {l, d};
    wr[ch] = wr[ch] + 1;
  endtask

  task automatic exp_byte(input logic [1:0] ch, input logic [7:0] d);
    exp_q.push_back({4'b0001 << ch, d});
  endtask

  task automatic exp_hdr(input logic [1:0] ch);
    if (HDR_ON) exp_byte(ch, {6'b111100, ch});
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] d);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_wr_o && tx_data_o == d) break;
    end
    chk(tag, 32'(i < 300), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o) break;
    end
    chk(tag, 32'(i < 400), 32'd1);
  endtask

  // Requester model: byte leaves its queue on valid & ready at the clock edge
  initial begin : driver
    forever begin
      @(posedge clk);
      for (int k = 0; k < N_CH; k++)
        if (req_valid[2'(k)] && req_ready_o[2'(k)]) rd[2'(k)] = rd[2'(k)] + 1;
      #1;
      for (int k = 0; k < N_CH; k++) begin
        if (rd[2'(k)] < wr[2'(k)]) begin
          req_valid[2'(k)]        = 1'b1;
          req_data[5'(8*k) +: 8]  = mem[2'(k)][4'(rd[2'(k)])][7:0];
          req_last[2'(k)]         = mem[2'(k)][4'(rd[2'(k)])][8];
        end else begin
          req_valid[2'(k)] = 1'b0;
          req_last[2'(k)]  = 1'b0;
        end
      end
    end
  end

  // Line monitor: every strobe pops one expected {grant, byte}
  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_wr_o) begin
        if (n_strobe > 0) chk("strobe_gap", 32'((cyc - last_strobe) >= 3), 32'd1);
        last_strobe = cyc;
        n_strobe++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {24'h0, tx_data_o}, 32'h100);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'h0, tx_data_o}, {24'h0, e[7:0]});
          chk("tx_grant", 32'(grant_o), 32'(e[11:8]));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          t;
    int          s0;
    logic        bad;
    for (int k = 0; k < N_CH; k++) begin
      rd[2'(k)] = 0;
      wr[2'(k)] = 0;
    end

    // Reset with every channel valid
    for (int k = 0; k < N_CH; k++) begin
      push(2'(k), 8'(k + 1), 1'b1);
      exp_hdr(2'(k));
      exp_byte(2'(k), 8'(k + 1));
    end
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_wr", 32'(tx_wr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_data", 32'(tx_data_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    arst = 1'b0;
    @(negedge clk);
    chk("first_grant", 32'(grant_o), 32'h1);
    chk("first_busy", 32'(busy_o), 32'd1);
    wait_idle("drain_reset");

    // Packet ownership with a competing valid channel
    push(2'd0, 8'h11, 1'b0); push(2'd0, 8'h22, 1'b0); push(2'd0, 8'h33, 1'b1);
    push(2'd1, 8'hAA, 1'b1);
    exp_hdr(2'd0); exp_byte(2'd0, 8'h11); exp_byte(2'd0, 8'h22); exp_byte(2'd0, 8'h33);
    exp_hdr(2'd1); exp_byte(2'd1, 8'hAA);
    wait_idle("drain_own");

    // Round robin, pointer resumes after channel 1
    for (int k = 0; k < N_CH; k++) begin
      push(2'(k), 8'hA0 + 8'(k), 1'b1);
      push(2'(k), 8'hA4 + 8'(k), 1'b1);
    end
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < N_CH; j++) begin
        exp_hdr(2'((2 + j) % 4));
        exp_byte(2'((2 + j) % 4), 8'hA0 + 8'(4 * r) + 8'((2 + j) % 4));
      end
    wait_idle("drain_rr");

    // Backpressure mid-packet
    push(2'd2, 8'hB1, 1'b0); push(2'd2, 8'hB2, 1'b0); push(2'd2, 8'hB3, 1'b1);
    exp_hdr(2'd2); exp_byte(2'd2, 8'hB1); exp_byte(2'd2, 8'hB2); exp_byte(2'd2, 8'hB3);
    wait_byte("bp_first", 8'hB1);
    tx_ready = 1'b0;
    @(negedge clk);
    s0 = n_strobe;
    bad = 1'b0;
    t = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready_o != '0) bad = 1'b1;
      if (timeout_o) t++;
    end
    chk("bp_ready", 32'(bad), 32'd0);
    chk("bp_timeout", t, 0);
    chk("bp_nostrobe", n_strobe - s0, 0);
    tx_ready = 1'b1;
    wait_byte("bp_resume", 8'hB2);
    wait_idle("drain_bp");

    // Stall timeout after a non-last byte, then channel 0 takes over
    push(2'd1, 8'hC1, 1'b0);
    exp_hdr(2'd1); exp_byte(2'd1, 8'hC1);
    wait_byte("to_first", 8'hC1);
    push(2'd0, 8'hC0, 1'b1);
    exp_hdr(2'd0); exp_byte(2'd0, 8'hC0);
    for (t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (timeout_o) break;
    end
    chk("to_latency", t, 18);
    chk("to_grant_clr", 32'(grant_o), 32'd0);
    @(negedge clk);
    chk("to_pulse_len", 32'(timeout_o), 32'd0);
    chk("to_regrant", 32'(grant_o), 32'h1);
    wait_idle("drain_to");

    // Enable dropped mid-packet: packet completes, then no new grant
    push(2'd3, 8'hD1, 1'b0); push(2'd3, 8'hD2, 1'b1); push(2'd0, 8'hD0, 1'b1);
    exp_hdr(2'd3); exp_byte(2'd3, 8'hD1); exp_byte(2'd3, 8'hD2);
    exp_hdr(2'd0); exp_byte(2'd0, 8'hD0);
    wait_byte("en_first", 8'hD1);
    en = 1'b0;
    wait_byte("en_complete", 8'hD2);
    repeat (2) @(negedge clk);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy_o || grant_o != '0) bad = 1'b1;
    end
    chk("en_hold_idle", 32'(bad), 32'd0);
    en = 1'b1;
    wait_idle("drain_en");

    // Clock enable low over a pending strobe
    push(2'd1, 8'hE1, 1'b1);
    exp_hdr(2'd1); exp_byte(2'd1, 8'hE1);
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready_o[1] && req_valid[1]) break;
    end
    chk("cke_accept_seen", 32'(t < 100), 32'd1);
    s0 = n_strobe;
    @(posedge clk);
    #1 cke = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_wr_o) bad = 1'b1;
    end
    chk("cke_hold_wr", 32'(bad), 32'd0);
    @(posedge clk);
    #1 cke = 1'b1;
    @(negedge clk);
    chk("cke_release_wr", 32'(tx_wr_o), 32'd1);
    repeat (4) @(negedge clk);
    chk("cke_one_strobe", n_strobe - s0, 1);
    wait_idle("drain_final");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
